// File: rtl/fc_operand_loader.sv
// Double-buffered byte-pair packer: 27 (activation, weight) beats into two 216-bit frames for the FC stage.
// Optional build macro FC_WEIGHT_HOLD_EN adds w_hold so one weight load can serve many frames.
module fc_operand_loader #(
    parameter int N_ELEM = 27,
    parameter int DW     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DW-1:0]          s_pool,
    input  logic [DW-1:0]          s_weight,
    input  logic                   s_last,
`ifdef FC_WEIGHT_HOLD_EN
    input  logic                   w_hold,
`endif
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [N_ELEM*DW-1:0]   pool_lin,
    output logic [N_ELEM*DW-1:0]   weight_lin,
    output logic                   frame_err
);

    localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);

    logic [N_ELEM*DW-1:0] pool_fill_r;
    logic [N_ELEM*DW-1:0] weight_fill_r;
    logic [N_ELEM*DW-1:0] pool_out_r;
    logic [N_ELEM*DW-1:0] weight_out_r;
    logic [4:0]           cnt_r;
    logic                 fill_full_r;
    logic                 m_valid_r;
    logic                 frame_err_r;

    logic                 xfer_s;
    logic                 s_ready_s;
    logic                 accept_s;
    logic                 last_beat_s;
    logic                 wr_weight_s;

    // Handshake decode; s_ready looks through to m_ready so a full fill buffer drains without a bubble
    always_comb begin
        xfer_s      = fill_full_r && (!m_valid_r || m_ready);
        s_ready_s   = !rst && (!fill_full_r || xfer_s);
        accept_s    = s_valid && s_ready_s;
        last_beat_s = (cnt_r == LAST_IDX);
`ifdef FC_WEIGHT_HOLD_EN
        wr_weight_s = !w_hold;
`else
        wr_weight_s = 1'b1;
`endif
    end

    // Fill/output buffer state; a beat completing a frame sets fill_full even when a transfer clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pool_fill_r   <= '0;
            weight_fill_r <= '0;
            pool_out_r    <= '0;
            weight_out_r  <= '0;
            cnt_r         <= 5'd0;
            fill_full_r   <= 1'b0;
            m_valid_r     <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            // The count is authoritative: s_last must coincide exactly with the final index
            frame_err_r <= accept_s && (s_last != last_beat_s);

            if (xfer_s) begin
                pool_out_r   <= pool_fill_r;
                weight_out_r <= weight_fill_r;
                m_valid_r    <= 1'b1;
                fill_full_r  <= 1'b0;
            end else if (m_valid_r && m_ready) begin
                m_valid_r <= 1'b0;
            end else begin
                m_valid_r <= m_valid_r;
            end

            if (accept_s) begin
                for (int k = 0; k < N_ELEM; k++) begin
                    if (cnt_r == 5'(k)) begin
                        pool_fill_r[k*DW +: DW] <= s_pool;
                        if (wr_weight_s) begin
                            weight_fill_r[k*DW +: DW] <= s_weight;
                        end
                    end
                end
                if (last_beat_s) begin
                    cnt_r       <= 5'd0;
                    fill_full_r <= 1'b1;
                end else if (s_last) begin
                    cnt_r <= 5'd0;
                end else begin
                    cnt_r <= cnt_r + 5'd1;
                end
            end
        end
    end

    assign s_ready    = s_ready_s;
    assign m_valid    = m_valid_r;
    assign pool_lin   = pool_out_r;
    assign weight_lin = weight_out_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_fc_operand_loader.sv
// Self-checking bench for fc_operand_loader: vector table, directed corner cases and a randomized
// stream checked by a frame-level scoreboard (frame order, frame_err timing, hold stability).
module tb_fc_operand_loader;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_pool;
    logic [7:0]   s_weight;
    logic         s_last;
    logic         w_hold;
    logic         m_valid;
    logic         m_ready;
    logic [215:0] pool_lin;
    logic [215:0] weight_lin;
    logic         frame_err;

    int tests = 0;
    int fails = 0;

    fc_operand_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_pool    (s_pool),
        .s_weight  (s_weight),
        .s_last    (s_last),
`ifdef FC_WEIGHT_HOLD_EN
        .w_hold    (w_hold),
`endif
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .pool_lin  (pool_lin),
        .weight_lin(weight_lin),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [215:0] act, input logic [215:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: frames as lists of beats ----------------
    typedef struct { logic [7:0] p; logic [7:0] w; } beat_t;
    typedef struct { logic [215:0] p; logic [215:0] w; } frame_t;

    beat_t        cur_q[$];
    frame_t       fq[$];
    logic [7:0]   wmem[27];
    logic         err_pend = 1'b0;
    logic         hold_v = 1'b0;
    logic [215:0] hold_p;
    logic [215:0] hold_w;

    always @(negedge clk) begin
        if (rst) begin
            cur_q.delete();
            fq.delete();
            err_pend = 1'b0;
            hold_v   = 1'b0;
            for (int i = 0; i < 27; i++) wmem[i] = 8'h00;
        end else begin
            chk("frame_err", {215'd0, frame_err}, {215'd0, err_pend});
            err_pend = 1'b0;
            if (hold_v) begin
                chk("hold_valid", {215'd0, m_valid}, 216'd1);
                chk("hold_pool", pool_lin, hold_p);
                chk("hold_weight", weight_lin, hold_w);
            end
            if (m_valid && m_ready) begin
                if (fq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got m_valid=1 expected no pending frame");
                end else begin
                    chk("sb_pool", pool_lin, fq[0].p);
                    chk("sb_weight", weight_lin, fq[0].w);
                    void'(fq.pop_front());
                end
            end
            hold_v = m_valid && !m_ready;
            hold_p = pool_lin;
            hold_w = weight_lin;
            if (s_valid && s_ready) begin
                int idx;
                beat_t bt;
                idx = cur_q.size();
                if (!w_hold) wmem[idx] = s_weight;
                bt.p = s_pool;
                bt.w = wmem[idx];
                cur_q.push_back(bt);
                if (cur_q.size() == 27) begin
                    frame_t f;
                    for (int i = 0; i < 27; i++) begin
                        f.p[i*8 +: 8] = cur_q[i].p;
                        f.w[i*8 +: 8] = cur_q[i].w;
                    end
                    fq.push_back(f);
                    err_pend = !s_last;
                    cur_q.delete();
                end else if (s_last) begin
                    err_pend = 1'b1;
                    cur_q.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] pb, input logic [7:0] wb, input bit winc,
                              input int n, input int last_at, input logic hold);
        for (int b = 0; b < n; b++) begin
            s_valid  = 1'b1;
            s_pool   = pb + 8'(b);
            s_weight = winc ? wb + 8'(b) : wb;
            s_last   = (b == last_at);
            w_hold   = hold;
            @(negedge clk);
            chk("beat_s_ready", {215'd0, s_ready}, 216'd1);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        w_hold  = 1'b0;
    endtask

    typedef struct {
        int         n;
        int         last_at;
        logic [7:0] pb;
        logic [7:0] wb;
        logic       exp_err;
        logic       exp_valid;
        logic [7:0] exp_lo;
        logic [7:0] exp_hi;
        logic [7:0] exp_whi;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int nv;
        tbl[0] = '{27, 26, 8'h00, 8'h80, 1'b0, 1'b1, 8'h00, 8'h1A, 8'h9A};
        tbl[1] = '{11, 10, 8'h40, 8'h50, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{27, 26, 8'h10, 8'h20, 1'b0, 1'b1, 8'h10, 8'h2A, 8'h3A};
        tbl[3] = '{27, -1, 8'h60, 8'hC0, 1'b1, 1'b1, 8'h60, 8'h7A, 8'hDA};

        rst = 1'b1; s_valid = 1'b0; s_pool = 8'h00; s_weight = 8'h00;
        s_last = 1'b0; w_hold = 1'b0; m_ready = 1'b1;
        repeat (2) tick();
        chk("rst_s_ready", {215'd0, s_ready}, 216'd0);
        chk("rst_m_valid", {215'd0, m_valid}, 216'd0);
        chk("rst_pool", pool_lin, 216'd0);
        chk("rst_weight", weight_lin, 216'd0);
        chk("rst_frame_err", {215'd0, frame_err}, 216'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", {215'd0, s_ready}, 216'd1);

        // Vector table: framing variants with the output always drained
        for (int t = 0; t < 4; t++) begin
            send_frame(tbl[t].pb, tbl[t].wb, 1'b1, tbl[t].n, tbl[t].last_at, 1'b0);
            @(negedge clk);
            chk("tbl_err_pulse", {215'd0, frame_err}, {215'd0, tbl[t].exp_err});
            chk("tbl_valid_early", {215'd0, m_valid}, 216'd0);
            tick();
            @(negedge clk);
            chk("tbl_valid", {215'd0, m_valid}, {215'd0, tbl[t].exp_valid});
            chk("tbl_err_done", {215'd0, frame_err}, 216'd0);
            if (tbl[t].exp_valid) begin
                chk("tbl_pool_lo", {208'd0, pool_lin[7:0]}, {208'd0, tbl[t].exp_lo});
                chk("tbl_pool_hi", {208'd0, pool_lin[215:208]}, {208'd0, tbl[t].exp_hi});
                chk("tbl_weight_hi", {208'd0, weight_lin[215:208]}, {208'd0, tbl[t].exp_whi});
            end
            tick();
            tick();
        end

        // Back-to-back frames under backpressure
        m_ready = 1'b0;
        send_frame(8'hA0, 8'h30, 1'b1, 27, 26, 1'b0);
        send_frame(8'hB0, 8'h60, 1'b1, 27, 26, 1'b0);
        @(negedge clk);
        chk("bp_s_ready_low", {215'd0, s_ready}, 216'd0);
        chk("bp_m_valid", {215'd0, m_valid}, 216'd1);
        chk("bp_frame1_lo", {208'd0, pool_lin[7:0]}, 216'hA0);
        repeat (3) tick();
        m_ready = 1'b1;
        #1;
        chk("bp_s_ready_same_cycle", {215'd0, s_ready}, 216'd1);
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        chk("bp_frame2_valid", {215'd0, m_valid}, 216'd1);
        chk("bp_frame2_lo", {208'd0, pool_lin[7:0]}, 216'hB0);
        chk("bp_frame2_hi", {208'd0, pool_lin[215:208]}, 216'hCA);
        tick();
        m_ready = 1'b1;
        repeat (2) tick();

        // Continuous stream: no s_ready gap, one m_valid cycle per 27 beats
        nv = 0;
        for (int b = 0; b < 81; b++) begin
            s_valid  = 1'b1;
            s_pool   = 8'($urandom);
            s_weight = 8'($urandom);
            s_last   = ((b % 27) == 26);
            @(negedge clk);
            chk("stream_s_ready", {215'd0, s_ready}, 216'd1);
            if (m_valid) nv++;
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (m_valid) nv++;
            tick();
        end
        chk("stream_frames", 216'(nv), 216'd3);

        // Reset mid-frame with a held output frame
        m_ready = 1'b0;
        send_frame(8'h11, 8'h22, 1'b1, 27, 26, 1'b0);
        send_frame(8'h90, 8'h91, 1'b1, 15, -1, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_m_valid", {215'd0, m_valid}, 216'd0);
        chk("midrst_pool", pool_lin, 216'd0);
        chk("midrst_weight", weight_lin, 216'd0);
        chk("midrst_s_ready", {215'd0, s_ready}, 216'd0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("midrst_release", {215'd0, s_ready}, 216'd1);
        send_frame(8'h50, 8'h70, 1'b1, 27, 26, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("midrst_frame_valid", {215'd0, m_valid}, 216'd1);
        chk("midrst_frame_lo", {208'd0, pool_lin[7:0]}, 216'h50);
        chk("midrst_frame_whi", {208'd0, weight_lin[215:208]}, 216'h8A);
        tick();

`ifdef FC_WEIGHT_HOLD_EN
        send_frame(8'h01, 8'h05, 1'b0, 27, 26, 1'b0);
        repeat (3) tick();
        send_frame(8'h33, 8'hFF, 1'b0, 27, 26, 1'b1);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("whold_valid", {215'd0, m_valid}, 216'd1);
        chk("whold_weights", weight_lin, {27{8'h05}});
        chk("whold_pool_lo", {208'd0, pool_lin[7:0]}, 216'h33);
        chk("whold_pool_hi", {208'd0, pool_lin[215:208]}, 216'h4D);
        tick();
`endif

        // Randomized traffic with occasional framing errors
        for (int c = 0; c < 1500; c++) begin
            s_valid  = ($urandom_range(0, 3) != 0);
            s_pool   = 8'($urandom);
            s_weight = 8'($urandom);
            if (cur_q.size() == 26) s_last = ($urandom_range(0, 9) != 0);
            else                    s_last = ($urandom_range(0, 39) == 0);
            m_ready  = ($urandom_range(0, 2) != 0);
`ifdef FC_WEIGHT_HOLD_EN
            w_hold   = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        w_hold  = 1'b0;
        m_ready = 1'b1;
        repeat (40) tick();
        chk("drain_empty", 216'(fq.size()), 216'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
